// File: rtl/game_pkg.sv
// Shared types and constants for the two-player game round controller.
package game_pkg;

    localparam int unsigned COORD_W = 6;
    localparam int unsigned SCORE_W = 6;
    localparam logic [SCORE_W-1:0] START_SCORE = 6'd50;

    typedef enum logic [2:0] {
        StIdle,
        StAim,
        StFire,
        StSettle,
        StCheck,
        StOver
    } game_state_e;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P0   = 2'b01;
    localparam logic [1:0] W_P1   = 2'b10;
    localparam logic [1:0] W_TIE  = 2'b11;

    // End-of-rounds verdict: the lower remaining score wins.
    function automatic logic [1:0] lower_score_winner(input logic [SCORE_W-1:0] s0,
                                                      input logic [SCORE_W-1:0] s1);
        if (s0 < s1) begin
            return W_P0;
        end else if (s1 < s0) begin
            return W_P1;
        end
        return W_TIE;
    endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn down-counter: loaded on clear, counts while enabled, flags zero.
module turn_timer #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // Reload on clear, otherwise count down and hold at zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/game_turn_controller.sv
// Round sequencer around the score block: shot capture, turn hand-over,
// round counting, per-turn timeout and end-of-game verdict.
module game_turn_controller
    import game_pkg::*;
#(
    parameter int unsigned MAX_ROUNDS = 10,
    parameter int unsigned TIMEOUT    = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               shot,
    input  logic [COORD_W-1:0] shot_x,
    input  logic [COORD_W-1:0] shot_y,
    input  logic [SCORE_W-1:0] score0,
    input  logic [SCORE_W-1:0] score1,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               player,
    output logic               valid_pulse,
    output logic               score_rst,
    output logic [3:0]         round,
    output logic               aiming,
    output logic               game_over,
    output logic [1:0]         winner
);

    localparam logic [3:0] ROUND_LAST = 4'(MAX_ROUNDS - 1);

    game_state_e        state;
    logic               game_begin;
    logic               timer_clear;
    logic               timer_expired;
    logic               last_turn;
    logic [SCORE_W-1:0] cur_score;

    // Decode helpers used by the FSM and the timer.
    always_comb begin
        game_begin  = start && ((state == StIdle) || (state == StOver));
        timer_clear = game_begin || (state == StCheck);
        cur_score   = player ? score1 : score0;
        last_turn   = player && (round == ROUND_LAST);
    end

    turn_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_turn_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .enable  (state == StAim),
        .expired (timer_expired)
    );

    // Game FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            x           <= '0;
            y           <= '0;
            player      <= 1'b0;
            round       <= '0;
            valid_pulse <= 1'b0;
            score_rst   <= 1'b0;
            aiming      <= 1'b0;
            game_over   <= 1'b0;
            winner      <= W_NONE;
        end else begin
            valid_pulse <= 1'b0;
            score_rst   <= 1'b0;
            case (state)
                StIdle, StOver: begin
                    if (start) begin
                        state     <= StAim;
                        score_rst <= 1'b1;
                        player    <= 1'b0;
                        round     <= '0;
                        winner    <= W_NONE;
                        aiming    <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                StAim: begin
                    // A shot on the expiry cycle still counts.
                    if (shot) begin
                        state       <= StFire;
                        x           <= shot_x;
                        y           <= shot_y;
                        valid_pulse <= 1'b1;
                        aiming      <= 1'b0;
                    end else if (timer_expired) begin
                        state  <= StCheck;
                        aiming <= 1'b0;
                    end
                end
                StFire: begin
                    state <= StSettle;
                end
                StSettle: begin
                    state <= StCheck;
                end
                StCheck: begin
                    if (cur_score == '0) begin
                        state     <= StOver;
                        game_over <= 1'b1;
                        winner    <= player ? W_P1 : W_P0;
                    end else if (last_turn) begin
                        state     <= StOver;
                        game_over <= 1'b1;
                        winner    <= lower_score_winner(score0, score1);
                    end else begin
                        player <= ~player;
                        if (player) begin
                            round <= round + 4'd1;
                        end
                        state  <= StAim;
                        aiming <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_turn_controller.sv
// Randomized bench for game_turn_controller with a stand-in score block and
// a turn-level reference model of the game rules.
module tb_game_turn_controller;
    import game_pkg::*;

    localparam int unsigned MAXR = 3;
    localparam int unsigned TOUT = 8;

    logic       clk = 1'b0;
    logic       rst, start, shot;
    logic [5:0] shot_x, shot_y, score0, score1, x, y;
    logic       player, valid_pulse, score_rst, aiming, game_over;
    logic [3:0] round;
    logic [1:0] winner;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state (game rules, one update per turn).
    int m_s0, m_s1, m_player, m_round, m_over, m_win, exp_vp;
    int aim_used;
    int vp_count;
    logic vp_prev;

    game_turn_controller #(
        .MAX_ROUNDS (MAXR),
        .TIMEOUT    (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .shot        (shot),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .score0      (score0),
        .score1      (score1),
        .x           (x),
        .y           (y),
        .player      (player),
        .valid_pulse (valid_pulse),
        .score_rst   (score_rst),
        .round       (round),
        .aiming      (aiming),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    // Shot value used by the stand-in score block.
    function automatic int shot_value(input int sx, input int sy);
        int s;
        s = sx + sy;
        if (s >= 90) return 40;
        if (s >= 36) return 20;
        if (s >= 10) return 10;
        return 0;
    endfunction

    function automatic logic [5:0] deduct(input logic [5:0] s, input int v);
        if (int'(s) > v) return 6'(int'(s) - v);
        return 6'd0;
    endfunction

    // Stand-in score block: reset to 50, deduct on falling edge of valid_pulse.
    always @(posedge clk) begin
        vp_prev <= rst ? 1'b0 : valid_pulse;
        if (valid_pulse) vp_count <= vp_count + 1;
        if (rst || score_rst) begin
            score0 <= START_SCORE;
            score1 <= START_SCORE;
        end else if (vp_prev && !valid_pulse) begin
            if (player) score1 <= deduct(score1, shot_value(int'(x), int'(y)));
            else        score0 <= deduct(score0, shot_value(int'(x), int'(y)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic check_status(input string pfx);
        check_val({pfx, ".player"}, 32'(player), m_player);
        check_val({pfx, ".round"}, 32'(round), m_round);
        check_val({pfx, ".game_over"}, 32'(game_over), m_over);
        check_val({pfx, ".winner"}, 32'(winner), m_win);
        check_val({pfx, ".aiming"}, 32'(aiming), (m_over != 0) ? 0 : 1);
        check_val({pfx, ".score0"}, 32'(score0), m_s0);
        check_val({pfx, ".score1"}, 32'(score1), m_s1);
        check_val({pfx, ".vp_count"}, 32'(vp_count), exp_vp);
    endtask

    // One turn by the game rules.
    task automatic model_turn(input bit took, input int sx, input int sy);
        int cur, v;
        if (took) begin
            v = shot_value(sx, sy);
            if (m_player != 0) m_s1 = (m_s1 > v) ? m_s1 - v : 0;
            else               m_s0 = (m_s0 > v) ? m_s0 - v : 0;
            exp_vp++;
        end
        cur = (m_player != 0) ? m_s1 : m_s0;
        if (cur == 0) begin
            m_over = 1;
            m_win  = (m_player != 0) ? 2 : 1;
        end else if (m_player == 1 && m_round == int'(MAXR) - 1) begin
            m_over = 1;
            m_win  = (m_s0 < m_s1) ? 1 : ((m_s0 > m_s1) ? 2 : 3);
        end else begin
            if (m_player == 1) m_round++;
            m_player = 1 - m_player;
        end
    endtask

    task automatic start_game(input string pfx);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_s0 = 50; m_s1 = 50; m_player = 0; m_round = 0; m_over = 0; m_win = 0;
        check_val({pfx, ".score_rst_hi"}, 32'(score_rst), 1);
        check_val({pfx, ".start_player"}, 32'(player), 0);
        check_val({pfx, ".start_round"}, 32'(round), 0);
        check_val({pfx, ".start_winner"}, 32'(winner), 0);
        check_val({pfx, ".start_aiming"}, 32'(aiming), 1);
        tick();
        check_val({pfx, ".score_rst_lo"}, 32'(score_rst), 0);
        check_status({pfx, ".started"});
        aim_used = 1;
    endtask

    // One turn: shot after d idle AIM cycles, or a full timeout.
    task automatic do_turn(input bit take, input int d, input logic [5:0] sx,
                           input logic [5:0] sy, input bit noise, input string pfx);
        if (take) begin
            repeat (d) begin
                if (noise && $urandom_range(0, 3) == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
            shot_x = sx; shot_y = sy; shot = 1'b1;
            tick();
            shot = 1'b0;
            check_val({pfx, ".vp_hi"}, 32'(valid_pulse), 1);
            check_val({pfx, ".x"}, 32'(x), 32'(sx));
            check_val({pfx, ".y"}, 32'(y), 32'(sy));
            if (noise) begin
                shot_x = 6'($urandom_range(0, 63));
                shot_y = 6'($urandom_range(0, 63));
                shot = 1'b1;
            end
            tick();
            shot = 1'b0;
            check_val({pfx, ".vp_lo"}, 32'(valid_pulse), 0);
            check_val({pfx, ".x_hold"}, 32'(x), 32'(sx));
            tick();
            if (noise) shot = 1'b1;
            tick();
            shot = 1'b0;
            model_turn(1'b1, int'(sx), int'(sy));
        end else begin
            repeat (TOUT - aim_used) begin
                if (noise && $urandom_range(0, 3) == 0) start = 1'b1;
                tick();
                start = 1'b0;
            end
            check_val({pfx, ".to_aiming"}, 32'(aiming), 0);
            check_val({pfx, ".to_vp"}, 32'(valid_pulse), 0);
            tick();
            model_turn(1'b0, 0, 0);
        end
        check_status(pfx);
        aim_used = 0;
    endtask

    task automatic after_over(input string pfx);
        repeat (3) begin
            shot_x = 6'($urandom_range(0, 63));
            shot_y = 6'($urandom_range(0, 63));
            shot = 1'b1;
            tick();
            shot = 1'b0;
            tick();
        end
        check_status({pfx, ".post_over"});
    endtask

    initial begin
        int turns, d;
        bit take;
        rst = 1'b1; start = 1'b0; shot = 1'b0; shot_x = '0; shot_y = '0;
        exp_vp = 0; aim_used = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_val("rst.x", 32'(x), 0);
        check_val("rst.y", 32'(y), 0);
        check_val("rst.player", 32'(player), 0);
        check_val("rst.round", 32'(round), 0);
        check_val("rst.vp", 32'(valid_pulse), 0);
        check_val("rst.score_rst", 32'(score_rst), 0);
        check_val("rst.aiming", 32'(aiming), 0);
        check_val("rst.game_over", 32'(game_over), 0);
        check_val("rst.winner", 32'(winner), 0);

        // Game 1: player0 is driven to zero with 20+20+10.
        start_game("g1");
        do_turn(1'b1, 0, 6'd12, 6'd25, 1'b0, "g1.t0");
        check_val("g1.score0_30", 32'(score0), 30);
        check_val("g1.player1", 32'(player), 1);
        do_turn(1'b1, 2, 6'd0, 6'd0, 1'b0, "g1.t1");
        do_turn(1'b1, 1, 6'd12, 6'd25, 1'b0, "g1.t2");
        do_turn(1'b1, 3, 6'd0, 6'd0, 1'b0, "g1.t3");
        do_turn(1'b1, 0, 6'd5, 6'd5, 1'b0, "g1.t4");
        check_val("g1.over", 32'(game_over), 1);
        check_val("g1.winner_p0", 32'(winner), 32'(W_P0));
        after_over("g1");

        // Game 2: from OVER; a timeout, then a shot on the expiry cycle.
        start_game("g2");
        do_turn(1'b0, 0, 6'd0, 6'd0, 1'b0, "g2.timeout");
        check_val("g2.to_player", 32'(player), 1);
        check_val("g2.to_score0", 32'(score0), 50);
        do_turn(1'b1, int'(TOUT) - 1 - aim_used, 6'd12, 6'd25, 1'b0, "g2.expiry_shot");
        check_val("g2.expiry_score1", 32'(score1), 30);
        turns = 0;
        while (m_over == 0 && turns < 12) begin
            do_turn(1'b1, 0, 6'd3, 6'd4, 1'b1, "g2.fill");
            turns++;
        end
        check_val("g2.ends", 32'(game_over), 1);

        // Game 3: all shots worth zero gives a tie in the last round.
        start_game("g3");
        repeat (2 * MAXR) do_turn(1'b1, 1, 6'd0, 6'd0, 1'b0, "g3.t");
        check_val("g3.winner_tie", 32'(winner), 32'(W_TIE));
        check_val("g3.round_last", 32'(round), MAXR - 1);
        after_over("g3");

        // Random games with stray start/shot pulses.
        for (int g = 0; g < 6; g++) begin
            start_game("rand");
            turns = 0;
            while (m_over == 0 && turns < 12) begin
                take = ($urandom_range(0, 3) != 0);
                d = int'($urandom_range(0, TOUT - 1 - aim_used));
                do_turn(take, d, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)),
                        1'b1, "rand");
                turns++;
            end
            check_val("rand.ends", 32'(game_over), 1);
            after_over("rand");
        end

        // Reset landing in FIRE aborts the game.
        start_game("rstfire");
        shot_x = 6'd12; shot_y = 6'd25; shot = 1'b1;
        tick();
        shot = 1'b0;
        check_val("rstfire.vp_hi", 32'(valid_pulse), 1);
        exp_vp++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rstfire.vp", 32'(valid_pulse), 0);
        check_val("rstfire.x", 32'(x), 0);
        check_val("rstfire.y", 32'(y), 0);
        check_val("rstfire.player", 32'(player), 0);
        check_val("rstfire.round", 32'(round), 0);
        check_val("rstfire.score_rst", 32'(score_rst), 0);
        check_val("rstfire.game_over", 32'(game_over), 0);
        check_val("rstfire.winner", 32'(winner), 0);
        repeat (3) tick();
        check_val("rstfire.idle_aiming", 32'(aiming), 0);
        check_val("rstfire.vp_count", 32'(vp_count), exp_vp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
